// File: rtl/systolic_job_sched_pkg.sv
// systolic_job_sched_pkg: scheduler states, array sizes and id-width helper
package systolic_job_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_START, S_WAIT, S_RESULT} state_t;
  localparam int SA_DEPTH  = 16;
  localparam int SA_WORD_W = 32;
  localparam int SA_RE_W   = 64;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/systolic_job_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr
module rr_arbiter
  import systolic_job_sched_pkg::*;
#(
  parameter int N = 2,
  localparam int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);
  always_comb begin
    idx = '0;
    // scan backwards so the smallest offset from ptr is written last
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = IDW'((int'(ptr) + i) % N);
    gnt = {N{|req}} & (N'(1) << idx);
  end
endmodule

// File: rtl/systolic_job_sched.sv
// systolic_job_sched: grants requesters round-robin, streams 16 words into the array,
// starts it, waits for done or timeout and returns the tagged result
module systolic_job_sched
  import systolic_job_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDW = id_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*SA_WORD_W-1:0] req_weight,
  input  logic [NUM_REQ*SA_WORD_W-1:0] req_act,
  input  logic [NUM_REQ*SA_WORD_W-1:0] req_scale,
  output logic                         sa_mem_we,
  output logic [3:0]                   sa_mem_addr,
  output logic [SA_WORD_W-1:0]         sa_weight_din,
  output logic [SA_WORD_W-1:0]         sa_act_din,
  output logic [SA_WORD_W-1:0]         sa_layer_scale,
  output logic                         sa_start,
  input  logic                         sa_done,
  input  logic [4*SA_RE_W-1:0]         sa_re,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [4*SA_RE_W-1:0]         res_data,
  output logic [IDW-1:0]               res_id,
  output logic                         res_err,
  output logic                         busy
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_t state;
  logic [IDW-1:0] g, ptr, arb_idx;
  logic [NUM_REQ-1:0] sel, arb_gnt;
  logic [3:0] cnt;
  logic [TW-1:0] tcnt;
  logic beat;
  logic [SA_WORD_W-1:0] w_sel, a_sel, s_sel;

  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req_valid), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx));

  assign req_ready = state == S_LOAD ? sel : '0;
  assign beat = |(req_valid & req_ready);
  assign busy = state != S_IDLE;
  assign w_sel = req_weight[SA_WORD_W*int'(g) +: SA_WORD_W];
  assign a_sel = req_act[SA_WORD_W*int'(g) +: SA_WORD_W];
  assign s_sel = req_scale[SA_WORD_W*int'(g) +: SA_WORD_W];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      g <= '0;
      sel <= '0;
      ptr <= '0;
      cnt <= '0;
      tcnt <= '0;
      sa_mem_we <= 1'b0;
      sa_mem_addr <= '0;
      sa_weight_din <= '0;
      sa_act_din <= '0;
      sa_layer_scale <= '0;
      sa_start <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
      res_err <= 1'b0;
    end else begin
      sa_mem_we <= 1'b0;
      sa_start <= 1'b0;
      case (state)
        S_IDLE:
          if (|req_valid) begin
            g <= arb_idx;
            sel <= arb_gnt;
            state <= S_LOAD;
          end
        S_LOAD:
          if (beat) begin
            sa_mem_we <= 1'b1;
            sa_mem_addr <= cnt;
            sa_weight_din <= w_sel;
            sa_act_din <= a_sel;
            if (cnt == 4'd0) sa_layer_scale <= s_sel;
            cnt <= cnt + 4'd1;
            if (cnt == 4'(SA_DEPTH - 1)) state <= S_DRAIN;
          end
        S_DRAIN: begin
          sa_start <= 1'b1;
          state <= S_START;
        end
        S_START: begin
          tcnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          // done on the final timeout cycle still counts as success
          if (sa_done || tcnt == TW'(TIMEOUT_CYC - 1)) begin
            res_data <= sa_done ? sa_re : '0;
            res_err <= !sa_done;
            res_id <= g;
            res_valid <= 1'b1;
            state <= S_RESULT;
          end else tcnt <= tcnt + TW'(1);
        S_RESULT:
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr <= g == IDW'(NUM_REQ - 1) ? '0 : g + IDW'(1);
            state <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_systolic_job_sched.sv
// tb_systolic_job_sched: directed scenario tasks with inline checks against hand-computed values
module tb_systolic_job_sched;
  logic clk = 0, rst = 0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [63:0] req_weight = '0, req_act = '0, req_scale = '0;
  logic sa_mem_we, sa_start, res_valid, res_err, busy;
  logic [3:0] sa_mem_addr;
  logic [31:0] sa_weight_din, sa_act_din, sa_layer_scale;
  logic sa_done = 0;
  logic [255:0] sa_re = '0, res_data;
  logic res_ready = 1;
  logic [0:0] res_id;
  int checks = 0, errors = 0, cyc = 0;
  logic done_en = 1;
  int done_dly = 5, done_cyc = 0;
  logic [3:0] wa[$];
  logic [31:0] ww[$], wx[$];
  int wc[$], grants[$];
  int n_start = 0, start_cyc = 0, both = 0, last_beat = 0, rv_cyc = 0, n_hs = 0;
  logic [1:0] prev_rdy = '0;
  logic prev_rv = 0;

  systolic_job_sched #(.NUM_REQ(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_weight(req_weight), .req_act(req_act), .req_scale(req_scale),
    .sa_mem_we(sa_mem_we), .sa_mem_addr(sa_mem_addr), .sa_weight_din(sa_weight_din),
    .sa_act_din(sa_act_din), .sa_layer_scale(sa_layer_scale), .sa_start(sa_start),
    .sa_done(sa_done), .sa_re(sa_re), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sa_mem_we) begin
      wa.push_back(sa_mem_addr);
      ww.push_back(sa_weight_din);
      wx.push_back(sa_act_din);
      wc.push_back(cyc);
    end
    if (sa_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (req_ready[0] && req_ready[1]) both++;
    if (req_ready != 2'b00 && prev_rdy == 2'b00) grants.push_back(int'(req_ready[1]));
    prev_rdy = req_ready;
    if ((req_valid & req_ready) != 2'b00) last_beat = cyc;
    if (res_valid && !prev_rv) rv_cyc = cyc;
    prev_rv = res_valid;
    if (res_valid && res_ready) n_hs++;
  end

  initial forever begin
    @(negedge clk);
    if (sa_start && done_en) begin
      repeat (done_dly) @(negedge clk);
      sa_done = 1;
      done_cyc = cyc;
      @(negedge clk);
      sa_done = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset;
    req_valid = '0;
    res_ready = 1;
    done_en = 1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic drive_job(input int id, input int gap, input int stop, input logic [31:0] scale);
    int k = 0, t = 0;
    logic fire, tog = 1;
    while (k < stop && t < 300) begin
      req_valid[id] = gap != 0 ? tog : 1'b1;
      req_weight[id*32 +: 32] = 32'(k + 1);
      req_act[id*32 +: 32] = 32'h100 + 32'(k);
      req_scale[id*32 +: 32] = k == 0 ? scale : scale + 32'h55;
      @(negedge clk);
      fire = req_valid[id] && req_ready[id];
      @(posedge clk);
      #1;
      if (fire) k++;
      t++;
      tog = ~tog;
    end
    req_valid[id] = 1'b0;
    checks++;
    if (k != stop) begin errors++; $display("FAIL load_beats: got %0d want %0d", k, stop); end
  endtask

  task automatic wait_res(input int lim);
    logic ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      #1 ok = res_valid;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL res_wait: got res_valid=0 want 1 within %0d cycles", lim); end
  endtask

  task automatic check_writes(input string name, input int w0);
    int bad = 0;
    if (wa.size() - w0 != 16) bad = 99;
    else
      for (int k = 0; k < 16; k++)
        if (wa[w0+k] !== 4'(k) || ww[w0+k] !== 32'(k + 1) || wx[w0+k] !== 32'h100 + 32'(k)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_writes: got %0d writes, %0d bad want 16, 0 bad", name, wa.size() - w0, bad); end
  endtask

  task automatic test_reset;
    rst = 0;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    checks++;
    if ({sa_mem_we, sa_start, res_valid, res_err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {sa_mem_we, sa_start, res_valid, res_err}); end
    checks++;
    if (res_data !== '0 || sa_layer_scale !== '0 || sa_mem_addr !== '0) begin errors++; $display("FAIL rst_data: got %h/%h/%h want 0", res_data, sa_layer_scale, sa_mem_addr); end
    req_valid = '0;
    do_reset;
  endtask

  task automatic test_single;
    logic [255:0] re = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    int w0, s0;
    do_reset;
    sa_re = re;
    done_dly = 5;
    w0 = wa.size();
    s0 = n_start;
    drive_job(0, 0, 16, 32'd7);
    wait_res(60);
    check_writes("t1", w0);
    checks++;
    if (wa.size() - w0 == 16 && wc[w0+15] - wc[w0] != 15) begin errors++; $display("FAIL t1_contig: got span %0d want 15", wc[w0+15] - wc[w0]); end
    checks++;
    if (sa_layer_scale !== 32'd7) begin errors++; $display("FAIL t1_scale: got %0d want 7", sa_layer_scale); end
    checks++;
    if (n_start - s0 != 1) begin errors++; $display("FAIL t1_starts: got %0d want 1", n_start - s0); end
    checks++;
    if (start_cyc - last_beat != 2) begin errors++; $display("FAIL t1_start_lat: got %0d want 2", start_cyc - last_beat); end
    checks++;
    if (rv_cyc - done_cyc != 1) begin errors++; $display("FAIL t1_done_lat: got %0d want 1", rv_cyc - done_cyc); end
    checks++;
    if (res_id !== 1'b0 || res_err !== 1'b0) begin errors++; $display("FAIL t1_id_err: got %b/%b want 0/0", res_id, res_err); end
    checks++;
    if (res_data !== re) begin errors++; $display("FAIL t1_data: got %h want %h", res_data, re); end
    @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_release: got %b/%b want 0/0", res_valid, busy); end
  endtask

  task automatic test_round_robin;
    int g0, b0, h0;
    do_reset;
    done_dly = 2;
    g0 = grants.size();
    b0 = both;
    h0 = n_hs;
    req_valid = 2'b11;
    for (int i = 0; i < 600 && n_hs - h0 < 4; i++) @(posedge clk);
    #1 req_valid = '0;
    checks++;
    if (n_hs - h0 != 4) begin errors++; $display("FAIL t2_jobs: got %0d want 4", n_hs - h0); end
    checks++;
    if (grants.size() - g0 < 4 || grants[g0] != 0 || grants[g0+1] != 1 || grants[g0+2] != 0 || grants[g0+3] != 1)
      begin errors++; $display("FAIL t2_order: got %0d grants want order 0,1,0,1", grants.size() - g0); end
    checks++;
    if (both != b0) begin errors++; $display("FAIL t2_both_ready: got %0d want 0", both - b0); end
  endtask

  task automatic test_gaps;
    int w0, s0;
    do_reset;
    sa_re = {4{64'h0123_4567_89AB_CDEF}};
    done_dly = 3;
    w0 = wa.size();
    s0 = n_start;
    drive_job(0, 1, 16, 32'd11);
    wait_res(60);
    check_writes("t3", w0);
    checks++;
    if (wa.size() - w0 == 16 && wc[w0+15] - wc[w0] <= 15) begin errors++; $display("FAIL t3_gaps: got span %0d want >15", wc[w0+15] - wc[w0]); end
    checks++;
    if (n_start - s0 != 1) begin errors++; $display("FAIL t3_starts: got %0d want 1", n_start - s0); end
    checks++;
    if (res_data !== {4{64'h0123_4567_89AB_CDEF}} || res_err !== 1'b0) begin errors++; $display("FAIL t3_result: got %h err %b", res_data, res_err); end
  endtask

  task automatic test_timeout;
    do_reset;
    done_en = 0;
    sa_re = {4{64'hFFFF_FFFF_FFFF_FFFF}};
    drive_job(1, 0, 16, 32'd3);
    wait_res(60);
    checks++;
    if (res_err !== 1'b1) begin errors++; $display("FAIL t4_err: got %b want 1", res_err); end
    checks++;
    if (res_data !== '0) begin errors++; $display("FAIL t4_data: got %h want 0", res_data); end
    checks++;
    if (res_id !== 1'b1) begin errors++; $display("FAIL t4_id: got %b want 1", res_id); end
    checks++;
    if (rv_cyc - (start_cyc + 1) != 8) begin errors++; $display("FAIL t4_timing: got %0d want 8", rv_cyc - (start_cyc + 1)); end
    done_en = 1;
  endtask

  task automatic test_backpressure;
    logic [255:0] re = {64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD};
    int s0, bad = 0;
    logic seen = 0;
    do_reset;
    res_ready = 0;
    sa_re = re;
    done_dly = 2;
    drive_job(0, 0, 16, 32'd5);
    wait_res(60);
    req_valid[1] = 1'b1;
    sa_re = ~re;
    s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (res_valid !== 1'b1 || res_data !== re || res_id !== 1'b0 || req_ready !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t5_stable: got %0d unstable cycles want 0", bad); end
    checks++;
    if (n_start != s0) begin errors++; $display("FAIL t5_start: got %0d starts want 0", n_start - s0); end
    res_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL t5_release: got %b want 0", res_valid); end
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready == 2'b10;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL t5_next_grant: got %b want 10", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_job;
    int w0;
    do_reset;
    done_dly = 2;
    drive_job(0, 0, 9, 32'd7);
    rst = 0;
    #1;
    checks++;
    if ({sa_mem_we, sa_start, res_valid, busy} !== 4'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL t6_flags: got %b/%b want 0000/00", {sa_mem_we, sa_start, res_valid, busy}, req_ready); end
    checks++;
    if (sa_mem_addr !== 4'd0 || sa_weight_din !== '0 || sa_act_din !== '0 || sa_layer_scale !== '0) begin errors++; $display("FAIL t6_regs: got %h/%h/%h/%h want 0", sa_mem_addr, sa_weight_din, sa_act_din, sa_layer_scale); end
    @(posedge clk);
    #1 rst = 1;
    w0 = wa.size();
    sa_re = {4{64'h5A5A}};
    drive_job(0, 0, 16, 32'd9);
    wait_res(60);
    check_writes("t6", w0);
    checks++;
    if (sa_layer_scale !== 32'd9 || res_err !== 1'b0 || res_data !== {4{64'h5A5A}}) begin errors++; $display("FAIL t6_result: got scale %0d err %b data %h", sa_layer_scale, res_err, res_data); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_gaps;
    test_timeout;
    test_backpressure;
    test_reset_mid_job;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
